universal_shift_register_p: RTL
===============================

Name: universal_shift_register_p

Overview:
- Parametrised universal shift register: WIDTH-bit data path, 8 per-cycle operating modes (hold, logical shifts, rotates, arithmetic shift, load, data clear).
- Adds an autonomous serialiser mode: on a start pulse it loads a word and shifts it out one bit per clock under an internal FSM, with busy and done status.
- Used as the general-purpose shift/serialise element in datapath and serial-link front ends.

Parameters:
- WIDTH, 8, data width in bits; must be 2 or more.
- CNT_W, $clog2(WIDTH), serialiser bit-counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge.
- clear  input  1  synchronous active-high reset.
- en  input  1  mode-operation enable while idle; 0 = hold.
- mode  input  3  operation select while idle (see Behaviour).
- p_in  input  WIDTH  parallel load data.
- msb_in  input  1  serial input for logical shift right and serialiser right.
- lsb_in  input  1  serial input for shift left and serialiser left.
- start  input  1  serialiser start pulse; sampled only when idle.
- dir  input  1  serialiser direction, sampled with start: 0 = right (LSB first), 1 = left (MSB first).
- p_out  output  WIDTH  register contents.
- ser_out  output  1  serial output (combinational from registers):
  - p_out[0] when latched direction = right.
  - p_out[WIDTH-1] when latched direction = left.
- busy  output  1  high while the serialiser is shifting; qualifies ser_out.
- done  output  1  one-cycle pulse after the final serial shift.

Behaviour:
- Reset: clear=1 at a clk edge gives:
  - p_out=0, busy=0, done=0, state=IDLE, counter=0, latched dir=0.
  - clear has priority over every other input, including mid-serialisation: the transfer is abandoned and no done pulse is produced.
- FSM states: IDLE, SHIFT.
- IDLE, start=1:
  - p_out<=p_in, latch dir, counter<=0, state<=SHIFT.
  - start overrides en and mode.
- IDLE, start=0, en=1: mode applied at the edge.
  - 000 hold.
  - 001 logical shift right: {msb_in, p_out[WIDTH-1:1]}.
  - 010 shift left: {p_out[WIDTH-2:0], lsb_in}.
  - 011 parallel load: p_in.
  - 100 rotate right: {p_out[0], p_out[WIDTH-1:1]}.
  - 101 rotate left: {p_out[WIDTH-2:0], p_out[WIDTH-1]}.
  - 110 arithmetic shift right: {p_out[WIDTH-1], p_out[WIDTH-1:1]}.
  - 111 data clear: p_out<=0; FSM unaffected.
- IDLE, start=0, en=0: p_out holds.
- SHIFT, every edge:
  - Shift in the latched direction: right inserts msb_in, left inserts lsb_in.
  - counter increments.
  - When counter==WIDTH-1 at the edge: the final shift is performed, state<=IDLE, done<=1.
- SHIFT, ignored inputs: en, mode, start, dir and p_in.
- Status timing:
  - busy = (state==SHIFT). It is high for exactly WIDTH cycles, starting the cycle after the start edge.
  - ser_out presents bit k of the loaded word in the k-th busy cycle (LSB-first for right, MSB-first for left).
  - done is registered, high for exactly one cycle, the first cycle after busy falls.
- Back-to-back transfers: start=1 while done=1 (state IDLE) is accepted; the new transfer begins the same edge.
- Latency: all mode operations take effect 1 cycle after the sampling edge.
- No combinational path from inputs to p_out, busy or done.

Test Plan:
- Reset:
  - Run any traffic, then clear=1 for 1 cycle mid-SHIFT.
  - Next cycle: p_out=0x00, busy=0, done=0, and no done pulse follows.
- Mode sweep (WIDTH=8): load 0xB4, then apply each mode one cycle each, reloading 0xB4 between steps, with msb_in=1 and lsb_in=1.
  - shr -> 0xDA.
  - shl -> 0x69.
  - rotr -> 0x5A.
  - rotl -> 0x69.
  - ashr -> 0xDA.
  - hold -> 0xB4.
  - data clear -> 0x00.
  - en=0 with mode=001 -> 0xB4 unchanged.
- Serialise right (WIDTH=8): p_in=0xA5, dir=0, msb_in=0, pulse start.
  - busy high for 8 cycles.
  - ser_out sequence 1,0,1,0,0,1,0,1.
  - done high exactly on cycle 9 after the start edge.
  - Final p_out=0x00.
- Serialise left: p_in=0xA5, dir=1, lsb_in=1, pulse start.
  - ser_out sequence 1,0,1,0,0,1,0,1.
  - Final p_out=0xFF.
  - done single-cycle.
- Busy immunity: during a transfer drive start=1, mode=011, en=1, p_in=0x00.
  - Serial sequence and done timing identical to the undisturbed run.
- Back-to-back and parameter sweep:
  - start asserted in the done cycle begins a second transfer with no idle gap.
  - Repeat the serialise-right check with WIDTH=2 and WIDTH=13: busy length equals WIDTH.

Source files
------------

// File: rtl/universal_shift_register_p.sv
// Universal shift register: eight per-cycle modes while idle, plus an
// autonomous serialiser that loads a word on start and shifts it out one bit per clock.
module universal_shift_register_p #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] p_in,
  input  logic             msb_in,
  input  logic             lsb_in,
  input  logic             start,
  input  logic             dir,
  output logic [WIDTH-1:0] p_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t                   state_p0, state_nx;
  logic        [WIDTH-1:0]  data_p0, data_nx;
  logic signed [WIDTH-1:0]  data_s;
  logic        [CNT_W-1:0]  cnt_p0, cnt_nx;
  logic                     dir_p0, dir_nx;
  logic                     done_p0, done_nx;

  assign data_s = data_p0;

  always_comb begin
    state_nx = state_p0;
    data_nx  = data_p0;
    cnt_nx   = cnt_p0;
    dir_nx   = dir_p0;
    done_nx  = 1'b0;
    unique case (state_p0)
      IDLE: begin
        if (start) begin
          data_nx  = p_in;
          dir_nx   = dir;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end else if (en) begin
          unique case (mode)
            3'b000: data_nx = data_p0;
            3'b001: data_nx = {msb_in, data_p0[WIDTH-1:1]};
            3'b010: data_nx = {data_p0[WIDTH-2:0], lsb_in};
            3'b011: data_nx = p_in;
            3'b100: data_nx = {data_p0[0], data_p0[WIDTH-1:1]};
            3'b101: data_nx = {data_p0[WIDTH-2:0], data_p0[WIDTH-1]};
            3'b110: data_nx = data_s >>> 1;
            3'b111: data_nx = '0;
          endcase
        end
      end
      SHIFT: begin
        // All mode/start inputs are ignored until the last bit leaves.
        data_nx = dir_p0 ? {data_p0[WIDTH-2:0], lsb_in} : {msb_in, data_p0[WIDTH-1:1]};
        cnt_nx  = cnt_p0 + 1'b1;
        if (cnt_p0 == LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // p0: single register stage for data, counter, latched direction and status
  always_ff @(posedge clk) begin
    if (clear) begin
      state_p0 <= IDLE;
      data_p0  <= '0;
      cnt_p0   <= '0;
      dir_p0   <= 1'b0;
      done_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nx;
      data_p0  <= data_nx;
      cnt_p0   <= cnt_nx;
      dir_p0   <= dir_nx;
      done_p0  <= done_nx;
    end
  end

  assign p_out   = data_p0;
  assign busy    = (state_p0 == SHIFT);
  assign done    = done_p0;
  assign ser_out = dir_p0 ? data_p0[WIDTH-1] : data_p0[0];

endmodule
